// File: rtl/region_priority_classifier.sv
// Two-stage pixel classifier: matches each scanned (row,col) against double-buffered
// rectangles and reports the lowest-index enabled region containing the pixel.
module region_priority_classifier #(
    parameter int COORD_W     = 7,
    parameter int NUM_REGIONS = 4,
    parameter int IDX_W       = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_wr,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic                   cfg_en,
    input  logic [COORD_W-1:0]     cfg_row_lo,
    input  logic [COORD_W-1:0]     cfg_row_hi,
    input  logic [COORD_W-1:0]     cfg_col_lo,
    input  logic [COORD_W-1:0]     cfg_col_hi,
    input  logic                   frame_start,
    input  logic                   pix_valid,
    input  logic [COORD_W-1:0]     row_now,
    input  logic [COORD_W-1:0]     col_now,
    output logic                   out_valid,
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_idx,
    output logic [NUM_REGIONS-1:0] hit_raw
);

    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] row_lo;
        logic [COORD_W-1:0] row_hi;
        logic [COORD_W-1:0] col_lo;
        logic [COORD_W-1:0] col_hi;
    } region_t;

    region_t shadow     [NUM_REGIONS];
    region_t shadow_nxt [NUM_REGIONS];
    region_t active     [NUM_REGIONS];

    logic [NUM_REGIONS-1:0] match;
    logic                   s1_valid;
    logic [NUM_REGIONS-1:0] s1_match;
    logic [IDX_W-1:0]       win_idx;

    // Indices with no matching region fall through unwritten, so illegal writes vanish.
    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            shadow_nxt[i] = shadow[i];
            if (cfg_wr && (int'(cfg_idx) == i)) begin
                shadow_nxt[i].en     = cfg_en;
                shadow_nxt[i].row_lo = cfg_row_lo;
                shadow_nxt[i].row_hi = cfg_row_hi;
                shadow_nxt[i].col_lo = cfg_col_lo;
                shadow_nxt[i].col_hi = cfg_col_hi;
            end
        end
    end

    // Committing from shadow_nxt lets a write in the frame_start cycle take effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                shadow[i] <= shadow_nxt[i];
                if (frame_start) begin
                    active[i] <= shadow_nxt[i];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            match[i] = active[i].en
                     && (row_now >= active[i].row_lo) && (row_now <= active[i].row_hi)
                     && (col_now >= active[i].col_lo) && (col_now <= active[i].col_hi);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_match <= '0;
        end else begin
            s1_valid <= pix_valid;
            s1_match <= pix_valid ? match : '0;
        end
    end

    // Scanning downward leaves the lowest set index as the winner.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (s1_match[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            hit       <= 1'b0;
            hit_idx   <= '0;
            hit_raw   <= '0;
        end else begin
            out_valid <= s1_valid;
            hit       <= s1_valid && (|s1_match);
            hit_idx   <= s1_valid ? win_idx : '0;
            hit_raw   <= s1_valid ? s1_match : '0;
        end
    end

endmodule

// File: tb/tb_region_priority_classifier.sv
// Directed bench for region_priority_classifier; IDX_W is widened to 3 so that
// out-of-range region indices can be driven.
module tb_region_priority_classifier;

    localparam int COORD_W     = 7;
    localparam int NUM_REGIONS = 4;
    localparam int IDX_W       = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_wr;
    logic [IDX_W-1:0]       cfg_idx;
    logic                   cfg_en;
    logic [COORD_W-1:0]     cfg_row_lo, cfg_row_hi, cfg_col_lo, cfg_col_hi;
    logic                   frame_start;
    logic                   pix_valid;
    logic [COORD_W-1:0]     row_now, col_now;
    logic                   out_valid;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [NUM_REGIONS-1:0] hit_raw;

    logic [8:0] obs;
    logic [8:0] exp_v;
    int n_compared   = 0;
    int n_mismatched = 0;

    assign obs = {out_valid, hit, hit_idx, hit_raw};

    always #5 clk = ~clk;

    region_priority_classifier #(
        .COORD_W     (COORD_W),
        .NUM_REGIONS (NUM_REGIONS),
        .IDX_W       (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_wr      (cfg_wr),
        .cfg_idx     (cfg_idx),
        .cfg_en      (cfg_en),
        .cfg_row_lo  (cfg_row_lo),
        .cfg_row_hi  (cfg_row_hi),
        .cfg_col_lo  (cfg_col_lo),
        .cfg_col_hi  (cfg_col_hi),
        .frame_start (frame_start),
        .pix_valid   (pix_valid),
        .row_now     (row_now),
        .col_now     (col_now),
        .out_valid   (out_valid),
        .hit         (hit),
        .hit_idx     (hit_idx),
        .hit_raw     (hit_raw)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [IDX_W-1:0] idx, input logic en,
                             input int rlo, input int rhi, input int clo, input int chi);
        cfg_wr     = 1'b1;
        cfg_idx    = idx;
        cfg_en     = en;
        cfg_row_lo = COORD_W'(rlo);
        cfg_row_hi = COORD_W'(rhi);
        cfg_col_lo = COORD_W'(clo);
        cfg_col_hi = COORD_W'(chi);
        step();
        cfg_wr     = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    // One isolated pixel followed by a bubble; its result is on the outputs afterwards.
    task automatic classify(input int r, input int c);
        pix_valid = 1'b1;
        row_now   = COORD_W'(r);
        col_now   = COORD_W'(c);
        step();
        pix_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_compared++;
        if (obs !== 9'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs actual=%b required=%b", obs, 9'b0);
        end
        rst       = 1'b0;
        pix_valid = 1'b1;
        row_now   = 7'd3;
        col_now   = 7'd3;
        step();
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_latency1 actual=%b required=%b", out_valid, 1'b0);
        end
        step();
        exp_v = {1'b1, 1'b0, 3'd0, 4'b0000};
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL reset_first_pixel actual=%b required=%b", obs, exp_v);
        end
        pix_valid = 1'b0;
        step();
        step();
        // Shadow write alone must not reach the active set.
        cfg_write(3'd0, 1'b1, 0, 10, 0, 10);
        classify(3, 3);
        exp_v = {1'b1, 1'b0, 3'd0, 4'b0000};
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL reset_no_commit actual=%b required=%b", obs, exp_v);
        end
    endtask

    task automatic test_priority();
        cfg_write(3'd0, 1'b1, 5, 5, 5, 5);
        cfg_write(3'd1, 1'b1, 4, 6, 4, 6);
        commit();
        classify(5, 5);
        exp_v = {1'b1, 1'b1, 3'd0, 4'b0011};
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL prio_55 actual=%b required=%b", obs, exp_v);
        end
        classify(4, 4);
        exp_v = {1'b1, 1'b1, 3'd1, 4'b0010};
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL prio_44 actual=%b required=%b", obs, exp_v);
        end
        classify(7, 7);
        exp_v = {1'b1, 1'b0, 3'd0, 4'b0000};
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL prio_77 actual=%b required=%b", obs, exp_v);
        end
        classify(5, 6);
        exp_v = {1'b1, 1'b1, 3'd1, 4'b0010};
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL prio_56 actual=%b required=%b", obs, exp_v);
        end
    endtask

    task automatic test_frame_boundary();
        cfg_write(3'd1, 1'b1, 0, 1, 0, 1);
        pix_valid = 1'b1;
        row_now   = 7'd4;
        col_now   = 7'd4;
        // Pixels 0..2 see the old set (pixel 2 shares the frame_start cycle); 3.. see the new.
        for (int cyc = 0; cyc < 6; cyc++) begin
            frame_start = (cyc == 2);
            step();
            if (cyc >= 1) begin
                exp_v = (cyc - 1 <= 2) ? {1'b1, 1'b1, 3'd1, 4'b0010} : {1'b1, 1'b0, 3'd0, 4'b0000};
                n_compared++;
                if (obs !== exp_v) begin
                    n_mismatched++;
                    $display("[TB] FAIL frame_pixel%0d actual=%b required=%b", cyc - 1, obs, exp_v);
                end
            end
        end
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        step();
        step();
    endtask

    task automatic test_inverted_bounds();
        logic [3:0] raw_e;
        logic [2:0] idx_e;
        cfg_write(3'd2, 1'b1, 9, 3, 0, 127);
        cfg_write(3'd3, 1'b1, 0, 127, 0, 127);
        commit();
        // Active: r0=(5,5) single pixel, r1=(0..1,0..1), r2 inverted, r3 full screen.
        for (int c = 0; c <= 128; c++) begin
            pix_valid = (c < 128);
            row_now   = COORD_W'(c);
            col_now   = COORD_W'(c);
            step();
            if (c >= 1) begin
                raw_e = {1'b1, 1'b0, (c - 1 <= 1), (c - 1 == 5)};
                idx_e = (c - 1 == 5) ? 3'd0 : ((c - 1 <= 1) ? 3'd1 : 3'd3);
                exp_v = {1'b1, 1'b1, idx_e, raw_e};
                n_compared++;
                if (obs !== exp_v) begin
                    n_mismatched++;
                    $display("[TB] FAIL sweep_rc%0d actual=%b required=%b", c - 1, obs, exp_v);
                end
            end
        end
        pix_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [9:0] pat;
        pat       = 10'b10_1101_0011;
        row_now   = 7'd5;
        col_now   = 7'd5;
        for (int c = 0; c <= 10; c++) begin
            pix_valid = (c < 10) ? pat[c] : 1'b0;
            step();
            if (c >= 1) begin
                exp_v = pat[c - 1] ? {1'b1, 1'b1, 3'd0, 4'b1001} : 9'b0;
                n_compared++;
                if (obs !== exp_v) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_slot%0d actual=%b required=%b", c - 1, obs, exp_v);
                end
            end
        end
        pix_valid = 1'b1;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_compared++;
        if (obs !== 9'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_flush actual=%b required=%b", obs, 9'b0);
        end
        step();
        step();
        exp_v = {1'b1, 1'b0, 3'd0, 4'b0000};
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_cleared actual=%b required=%b", obs, exp_v);
        end
        pix_valid = 1'b0;
        step();
        commit();
        classify(5, 5);
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_shadow actual=%b required=%b", obs, exp_v);
        end
    endtask

    task automatic test_config_corner();
        cfg_write(3'd4, 1'b1, 0, 127, 0, 127);
        cfg_write(3'd7, 1'b1, 0, 127, 0, 127);
        commit();
        classify(10, 10);
        exp_v = {1'b1, 1'b0, 3'd0, 4'b0000};
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL illegal_idx actual=%b required=%b", obs, exp_v);
        end
        cfg_wr      = 1'b1;
        cfg_idx     = 3'd2;
        cfg_en      = 1'b1;
        cfg_row_lo  = 7'd10;
        cfg_row_hi  = 7'd10;
        cfg_col_lo  = 7'd10;
        cfg_col_hi  = 7'd10;
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        row_now     = 7'd10;
        col_now     = 7'd10;
        step();
        cfg_wr      = 1'b0;
        frame_start = 1'b0;
        step();
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL same_cycle_old actual=%b required=%b", obs, exp_v);
        end
        pix_valid = 1'b0;
        step();
        exp_v = {1'b1, 1'b1, 3'd2, 4'b0100};
        n_compared++;
        if (obs !== exp_v) begin
            n_mismatched++;
            $display("[TB] FAIL same_cycle_new actual=%b required=%b", obs, exp_v);
        end
    endtask

    initial begin
        rst         = 1'b1;
        cfg_wr      = 1'b0;
        cfg_idx     = '0;
        cfg_en      = 1'b0;
        cfg_row_lo  = '0;
        cfg_row_hi  = '0;
        cfg_col_lo  = '0;
        cfg_col_hi  = '0;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        row_now     = '0;
        col_now     = '0;
        test_reset();
        test_priority();
        test_frame_boundary();
        test_inverted_bounds();
        test_back_to_back();
        test_config_corner();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
